// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: several pipelined masters share one slave.
// One master owns the slave from the cycle after it wins arbitration until it
// drops cyc; in-flight requests are counted so the owner can be throttled.
module wb_rr_arbiter #(
    parameter int g_num_masters     = 4,
    parameter int g_addr_width      = 32,
    parameter int g_data_width      = 32,
    parameter int g_max_outstanding = 15
) (
    input  logic                                      clk_sys_i,
    input  logic                                      rst_n_i,
    // master-side ports, master k occupies bit / slice k
    input  logic [g_num_masters-1:0]                  s_cyc_i,
    input  logic [g_num_masters-1:0]                  s_stb_i,
    input  logic [g_num_masters-1:0]                  s_we_i,
    input  logic [g_num_masters*g_addr_width-1:0]     s_adr_i,
    input  logic [g_num_masters*g_data_width-1:0]     s_dat_i,
    input  logic [g_num_masters*(g_data_width/8)-1:0] s_sel_i,
    output logic [g_data_width-1:0]                   s_dat_o,
    output logic [g_num_masters-1:0]                  s_ack_o,
    output logic [g_num_masters-1:0]                  s_err_o,
    output logic [g_num_masters-1:0]                  s_rty_o,
    output logic [g_num_masters-1:0]                  s_stall_o,
    // shared slave port
    output logic                                      m_cyc_o,
    output logic                                      m_stb_o,
    output logic                                      m_we_o,
    output logic [g_addr_width-1:0]                   m_adr_o,
    output logic [g_data_width-1:0]                   m_dat_o,
    output logic [g_data_width/8-1:0]                 m_sel_o,
    input  logic [g_data_width-1:0]                   m_dat_i,
    input  logic                                      m_ack_i,
    input  logic                                      m_err_i,
    input  logic                                      m_rty_i,
    input  logic                                      m_stall_i,
    // one-hot current owner, zero when idle
    output logic [g_num_masters-1:0]                  grant_o
);

    localparam int SEL_W = g_data_width / 8;
    localparam int IDX_W = $clog2(g_num_masters);
    localparam int CNT_W = $clog2(g_max_outstanding + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(g_max_outstanding);
    // Last owner after reset is the top index so master 0 is searched first.
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(g_num_masters - 1);
    localparam logic [IDX_W:0]   NUM_EXT   = (IDX_W + 1)'(g_num_masters);

    // Per-master views of the flattened buses.
    logic [g_addr_width-1:0] adr_arr [g_num_masters];
    logic [g_data_width-1:0] dat_arr [g_num_masters];
    logic [SEL_W-1:0]        sel_arr [g_num_masters];

    logic [0:0]               state_reg, state_next;
    logic [IDX_W-1:0]         owner_reg, owner_next;
    logic [g_num_masters-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]         last_reg, last_next;
    logic [CNT_W-1:0]         outstanding_reg, outstanding_next;

    logic             owned;
    logic             own_cyc;
    logic             throttle;
    logic             resp_any;
    logic             resp_en;
    logic             accept;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand_idx;

    generate
        for (genvar gi = 0; gi < g_num_masters; gi++) begin : g_slice
            assign adr_arr[gi] = s_adr_i[gi*g_addr_width +: g_addr_width];
            assign dat_arr[gi] = s_dat_i[gi*g_data_width +: g_data_width];
            assign sel_arr[gi] = s_sel_i[gi*SEL_W +: SEL_W];
        end
    endgenerate

    // Reset is folded in combinationally so an owner's transfer is cut off
    // in the very cycle reset is asserted, not one cycle later.
    assign owned    = (state_reg == ST_OWNED) && rst_n_i;
    assign own_cyc  = s_cyc_i[owner_reg];
    assign throttle = (outstanding_reg == MAX_CNT);
    assign resp_any = m_ack_i | m_err_i | m_rty_i;
    assign resp_en  = owned & own_cyc;
    assign accept   = m_stb_o & ~m_stall_i;

    // Shared slave request follows the owner's slice; quiet when idle.
    assign m_cyc_o = owned & own_cyc;
    assign m_stb_o = owned & s_stb_i[owner_reg] & ~throttle;
    assign m_we_o  = owned & s_we_i[owner_reg];
    assign m_adr_o = owned ? adr_arr[owner_reg] : '0;
    assign m_dat_o = owned ? dat_arr[owner_reg] : '0;
    assign m_sel_o = owned ? sel_arr[owner_reg] : '0;

    assign s_dat_o = m_dat_i;
    assign grant_o = grant_reg;

    // Responses reach only the owner and only while it still holds cyc;
    // everyone else is stalled.
    generate
        for (genvar gi = 0; gi < g_num_masters; gi++) begin : g_resp
            assign s_ack_o[gi]   = resp_en & grant_reg[gi] & m_ack_i;
            assign s_err_o[gi]   = resp_en & grant_reg[gi] & m_err_i;
            assign s_rty_o[gi]   = resp_en & grant_reg[gi] & m_rty_i;
            assign s_stall_o[gi] = ~(owned & grant_reg[gi]) | m_stall_i | throttle;
        end
    endgenerate

    // Round-robin search: first requester strictly after the last owner,
    // wrapping, so the previous owner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int i = 1; i <= g_num_masters; i++) begin
            cand_sum = {1'b0, last_reg} + (IDX_W + 1)'(i);
            if (cand_sum >= NUM_EXT) begin
                cand_sum = cand_sum - NUM_EXT;
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (!pick_found && s_cyc_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Ownership hand-over and in-flight request bookkeeping.
    always_comb begin
        state_next       = state_reg;
        owner_next       = owner_reg;
        grant_next       = grant_reg;
        last_next        = last_reg;
        outstanding_next = outstanding_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next           = ST_OWNED;
                    owner_next           = pick_idx;
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    outstanding_next     = '0;
                end
            end
            ST_OWNED: begin
                if (!own_cyc) begin
                    // Owner ended its cycle: late responses are dropped
                    // because nobody is granted any more.
                    state_next       = ST_IDLE;
                    grant_next       = '0;
                    last_next        = owner_reg;
                    outstanding_next = '0;
                end else if (accept && !resp_any) begin
                    if (outstanding_reg != MAX_CNT) begin
                        outstanding_next = outstanding_reg + 1'b1;
                    end
                end else if (!accept && resp_any) begin
                    // A spurious response with nothing in flight is still
                    // forwarded but must not underflow the count.
                    if (outstanding_reg != '0) begin
                        outstanding_next = outstanding_reg - 1'b1;
                    end
                end
            end
            default: begin
                state_next       = ST_IDLE;
                grant_next       = '0;
                outstanding_next = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= '0;
            grant_reg       <= '0;
            last_reg        <= LAST_INIT;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            owner_reg       <= owner_next;
            grant_reg       <= grant_next;
            last_reg        <= last_next;
            outstanding_reg <= outstanding_next;
        end
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter g_num_masters, default 4, number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter g_addr_width, default 32, address width.
REQ-003 SHALL have parameter g_data_width, default 32, data width; byte-select width is g_data_width/8.
REQ-004 SHALL have parameter g_max_outstanding, default 15, maximum in-flight pipelined requests (1..255).
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 clk_sys_i  in  1  system clock; all logic on its rising edge.
REQ-007 rst_n_i  in  1  synchronous active-low reset.
REQ-008 s_cyc_i, s_stb_i, s_we_i  in  g_num_masters each  per-master cycle, strobe and write-enable; bit k belongs to master k.
REQ-009 s_adr_i  in  g_num_masters*g_addr_width  per-master address; master k occupies slice k.
REQ-010 s_dat_i  in  g_num_masters*g_data_width  per-master write data.
REQ-011 s_sel_i  in  g_num_masters*g_data_width/8  per-master byte selects.
REQ-012 s_dat_o  out  g_data_width  read data, broadcast to all masters.
REQ-013 s_ack_o, s_err_o, s_rty_o, s_stall_o  out  g_num_masters each  per-master response and stall.
REQ-014 m_cyc_o, m_stb_o, m_we_o  out  1 each; m_adr_o  out  g_addr_width; m_dat_o  out  g_data_width; m_sel_o  out  g_data_width/8  shared-slave request.
REQ-015 m_dat_i  in  g_data_width; m_ack_i, m_err_i, m_rty_i, m_stall_i  in  1 each  shared-slave response.
REQ-016 grant_o  out  g_num_masters  one-hot current owner, all-zero when idle.

Function
REQ-017 SHALL implement two states: IDLE (no owner) and OWNED (exactly one owner g).
REQ-018 In IDLE with any s_cyc_i bit set, SHALL select the first requester searching upward (wrapping) from index last+1, last being the previous owner, and enter OWNED next cycle; arbitration latency exactly 1 cycle.
REQ-019 In IDLE, m_cyc_o and m_stb_o SHALL be 0 and all s_stall_o bits SHALL be 1.
REQ-020 In OWNED, m_cyc_o, m_we_o, m_adr_o, m_dat_o, m_sel_o SHALL combinationally follow master g's slice.
REQ-021 In OWNED, m_stb_o SHALL equal s_stb_i[g] AND NOT throttle, throttle = (outstanding == g_max_outstanding).
REQ-022 s_stall_o[g] SHALL equal m_stall_i OR throttle; s_stall_o[k], k != g, SHALL be 1.
REQ-023 s_ack_o[g], s_err_o[g], s_rty_o[g] SHALL follow m_ack_i, m_err_i, m_rty_i only while OWNED and s_cyc_i[g]=1; all other bits SHALL be 0.
REQ-024 Outstanding counter SHALL increment on m_stb_o AND NOT m_stall_i, decrement on any of m_ack_i/m_err_i/m_rty_i, remain unchanged when both occur in one cycle, and never wrap below 0 or above g_max_outstanding.
REQ-025 When s_cyc_i[g] falls, SHALL return to IDLE next cycle, clear outstanding to 0, record last=g, and drop responses arriving afterwards.
REQ-026 Grant SHALL NOT change while s_cyc_i[g]=1 regardless of other requests (no preemption).
REQ-027 A master re-asserting cyc in the cycle its grant is released SHALL be considered only after all other pending masters in round-robin order.
REQ-028 Response received with outstanding = 0 SHALL be forwarded but SHALL NOT decrement the counter.

Reset
REQ-029 While rst_n_i=0 at a clock edge: state=IDLE, grant_o=0, outstanding=0, last=g_num_masters-1 (so master 0 has first priority), m_cyc_o=0, m_stb_o=0, s_ack_o/s_err_o/s_rty_o=0, s_stall_o=all ones.
REQ-030 Reset asserted mid-transfer SHALL abort the owner's cycle in that cycle without a response.

Verification
REQ-031 After reset, masters 1 and 3 raise cyc together -> grant_o=0b0010 one cycle later; master 1 drops cyc -> grant_o=0 next cycle, then 0b1000.
REQ-032 All four masters hold cyc continuously, each releasing after one transfer -> grant order 0,1,2,3,0.
REQ-033 g_max_outstanding=2, slave never acks, owner strobes 4 times with m_stall_i=0 -> exactly 2 m_stb_o accepted, s_stall_o[g]=1 until an ack arrives.
REQ-034 Slave asserts m_stall_i=1 for 3 cycles during a burst -> owner's stall is 1 for those cycles, non-owners' stall is 1 throughout, counter unchanged.
REQ-035 Strobe accepted and ack returned in the same cycle at outstanding=1 -> outstanding remains 1.
REQ-036 rst_n_i pulled low for one cycle with 3 outstanding -> next cycle grant_o=0, m_cyc_o=0, outstanding=0, and a late m_ack_i produces no s_ack_o.
